ic0_arb: RTL and testbench

IC0_ARB -- requirements
Module: ic0_arb

---
 rtl/ic0_arb.sv | 166 ++++++++++++++++
 tb/tb_ic0_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ic0_arb.sv
// ic0_arb: two-master round-robin arbiter for the shared ic0 bus.
// Each grant runs one write, or one read that waits for the first of four
// slave responses. A read with no response inside RD_TIMEOUT cycles returns
// ERR_DATA and sets the sticky err_timeout flag.
module ic0_arb #(
  parameter int unsigned RD_TIMEOUT = 16,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        c_sys_rst,
  // master 0
  input  logic        m0_wr_valid,
  input  logic        m0_rd_valid,
  input  logic [31:0] m0_wr_addr,
  input  logic [31:0] m0_wr_data,
  input  logic [31:0] m0_rd_addr,
  output logic        m0_gnt,
  output logic        m0_rd_ready,
  output logic [31:0] m0_rd_data,
  // master 1
  input  logic        m1_wr_valid,
  input  logic        m1_rd_valid,
  input  logic [31:0] m1_wr_addr,
  input  logic [31:0] m1_wr_data,
  input  logic [31:0] m1_rd_addr,
  output logic        m1_gnt,
  output logic        m1_rd_ready,
  output logic [31:0] m1_rd_data,
  // shared bus, master side
  output logic        ic0_c_axi_mst_wr_valid,
  output logic        ic0_c_axi_mst_rd_valid,
  output logic [31:0] ic0_axi_mst_wr_addr,
  output logic [31:0] ic0_axi_mst_wr_data,
  output logic [31:0] ic0_axi_mst_rd_addr,
  // shared bus, slave read responses
  input  logic        ic0_c_axi_slv_rd_ready_0,
  input  logic        ic0_c_axi_slv_rd_ready_1,
  input  logic        ic0_c_axi_slv_rd_ready_2,
  input  logic        ic0_c_axi_slv_rd_ready_3,
  input  logic [31:0] ic0_axi_slv_rd_data_0,
  input  logic [31:0] ic0_axi_slv_rd_data_1,
  input  logic [31:0] ic0_axi_slv_rd_data_2,
  input  logic [31:0] ic0_axi_slv_rd_data_3,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

  // Counter only needs to reach RD_TIMEOUT-1; the timeout fires on that value.
  localparam int unsigned CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          last_gnt;   // index of the master granted most recently
  logic          cur;        // master owning the transaction in flight

  logic          req0, req1, any_req, pick, sel_wr;
  logic [31:0]   sel_wr_addr, sel_wr_data, sel_rd_addr;
  logic          resp_hit;
  logic [31:0]   resp_data;

  // Round-robin pick between requesting masters, write before read within one.
  always_comb begin
    req0        = m0_wr_valid | m0_rd_valid;
    req1        = m1_wr_valid | m1_rd_valid;
    any_req     = req0 | req1;
    pick        = (req0 && req1) ? ~last_gnt : req1;
    sel_wr      = pick ? m1_wr_valid : m0_wr_valid;
    sel_wr_addr = pick ? m1_wr_addr  : m0_wr_addr;
    sel_wr_data = pick ? m1_wr_data  : m0_wr_data;
    sel_rd_addr = pick ? m1_rd_addr  : m0_rd_addr;
  end

  // Lowest-index slave response wins when several arrive together.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    resp_hit  = 1'b0;
    resp_data = '0;
    if (ic0_c_axi_slv_rd_ready_0) begin
      resp_hit  = 1'b1;
      resp_data = ic0_axi_slv_rd_data_0;
    end else if (ic0_c_axi_slv_rd_ready_1) begin
      resp_hit  = 1'b1;
      resp_data = ic0_axi_slv_rd_data_1;
    end else if (ic0_c_axi_slv_rd_ready_2) begin
      resp_hit  = 1'b1;
      resp_data = ic0_axi_slv_rd_data_2;
    end else if (ic0_c_axi_slv_rd_ready_3) begin
      resp_hit  = 1'b1;
      resp_data = ic0_axi_slv_rd_data_3;
    end
  end

  // Transaction FSM with all outputs registered; reset overrides everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (c_sys_rst) begin
      state                  <= IDLE;
      wait_cnt               <= '0;
      last_gnt               <= 1'b1;
      cur                    <= 1'b0;
      m0_gnt                 <= 1'b0;
      m1_gnt                 <= 1'b0;
      m0_rd_ready            <= 1'b0;
      m1_rd_ready            <= 1'b0;
      m0_rd_data             <= '0;
      m1_rd_data             <= '0;
      ic0_c_axi_mst_wr_valid <= 1'b0;
      ic0_c_axi_mst_rd_valid <= 1'b0;
      ic0_axi_mst_wr_addr    <= '0;
      ic0_axi_mst_wr_data    <= '0;
      ic0_axi_mst_rd_addr    <= '0;
      err_timeout            <= 1'b0;
    end else begin
      // pulses and strobes default low; data/address registers hold
      m0_gnt                 <= 1'b0;
      m1_gnt                 <= 1'b0;
      m0_rd_ready            <= 1'b0;
      m1_rd_ready            <= 1'b0;
      ic0_c_axi_mst_wr_valid <= 1'b0;
      ic0_c_axi_mst_rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cur      <= pick;
            last_gnt <= pick;
            if (pick) m1_gnt <= 1'b1;
            else      m0_gnt <= 1'b1;
            if (sel_wr) begin
              ic0_c_axi_mst_wr_valid <= 1'b1;
              ic0_axi_mst_wr_addr    <= sel_wr_addr;
              ic0_axi_mst_wr_data    <= sel_wr_data;
              state                  <= WR;
            end else begin
              ic0_c_axi_mst_rd_valid <= 1'b1;
              ic0_axi_mst_rd_addr    <= sel_rd_addr;
              wait_cnt               <= '0;
              state                  <= RD;
            end
          end
        end
        WR: state <= IDLE;
        RD, RD_WAIT: begin
          if (resp_hit || wait_cnt == CNT_LAST) begin
            if (cur) begin
              m1_rd_ready <= 1'b1;
              m1_rd_data  <= resp_hit ? resp_data : ERR_DATA;
            end else begin
              m0_rd_ready <= 1'b1;
              m0_rd_data  <= resp_hit ? resp_data : ERR_DATA;
            end
            if (!resp_hit) err_timeout <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            state    <= RD_WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ic0_arb.sv
// Directed testbench for ic0_arb: reset, arbitration order, write issue,
// read returns, response priority, timeout and reset-during-read.
module tb_ic0_arb;

  logic        clk = 1'b0;
  logic        c_sys_rst;
  logic        m0_wr_valid, m0_rd_valid, m1_wr_valid, m1_rd_valid;
  logic [31:0] m0_wr_addr, m0_wr_data, m0_rd_addr;
  logic [31:0] m1_wr_addr, m1_wr_data, m1_rd_addr;
  logic        m0_gnt, m0_rd_ready, m1_gnt, m1_rd_ready;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        wr_valid, rd_valid;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic        s_rdy0, s_rdy1, s_rdy2, s_rdy3;
  logic [31:0] s_dat0, s_dat1, s_dat2, s_dat3;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  ic0_arb dut (
    .clk                      (clk),
    .c_sys_rst                (c_sys_rst),
    .m0_wr_valid              (m0_wr_valid),
    .m0_rd_valid              (m0_rd_valid),
    .m0_wr_addr               (m0_wr_addr),
    .m0_wr_data               (m0_wr_data),
    .m0_rd_addr               (m0_rd_addr),
    .m0_gnt                   (m0_gnt),
    .m0_rd_ready              (m0_rd_ready),
    .m0_rd_data               (m0_rd_data),
    .m1_wr_valid              (m1_wr_valid),
    .m1_rd_valid              (m1_rd_valid),
    .m1_wr_addr               (m1_wr_addr),
    .m1_wr_data               (m1_wr_data),
    .m1_rd_addr               (m1_rd_addr),
    .m1_gnt                   (m1_gnt),
    .m1_rd_ready              (m1_rd_ready),
    .m1_rd_data               (m1_rd_data),
    .ic0_c_axi_mst_wr_valid   (wr_valid),
    .ic0_c_axi_mst_rd_valid   (rd_valid),
    .ic0_axi_mst_wr_addr      (wr_addr),
    .ic0_axi_mst_wr_data      (wr_data),
    .ic0_axi_mst_rd_addr      (rd_addr),
    .ic0_c_axi_slv_rd_ready_0 (s_rdy0),
    .ic0_c_axi_slv_rd_ready_1 (s_rdy1),
    .ic0_c_axi_slv_rd_ready_2 (s_rdy2),
    .ic0_c_axi_slv_rd_ready_3 (s_rdy3),
    .ic0_axi_slv_rd_data_0    (s_dat0),
    .ic0_axi_slv_rd_data_1    (s_dat1),
    .ic0_axi_slv_rd_data_2    (s_dat2),
    .ic0_axi_slv_rd_data_3    (s_dat3),
    .err_timeout              (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_slaves();
    {s_rdy0, s_rdy1, s_rdy2, s_rdy3} = '0;
    {s_dat0, s_dat1, s_dat2, s_dat3} = '0;
  endtask

  initial begin
    c_sys_rst = 1'b1;
    {m0_wr_valid, m0_rd_valid, m1_wr_valid, m1_rd_valid} = '0;
    {m0_wr_addr, m0_wr_data, m0_rd_addr} = '0;
    {m1_wr_addr, m1_wr_data, m1_rd_addr} = '0;
    clear_slaves();

    // reset state
    step(2);
    check("rst_m0_gnt",  {31'd0, m0_gnt}, 0);
    check("rst_m1_gnt",  {31'd0, m1_gnt}, 0);
    check("rst_wr_valid",{31'd0, wr_valid}, 0);
    check("rst_rd_valid",{31'd0, rd_valid}, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_m0_data", m0_rd_data, 0);
    check("rst_err",     {31'd0, err_timeout}, 0);
    c_sys_rst = 1'b0;

    // both masters read from reset: m0 wins the first tie
    m0_rd_valid = 1'b1; m0_rd_addr = 32'h100;
    m1_rd_valid = 1'b1; m1_rd_addr = 32'h200;
    step();
    check("tie1_m0_gnt", {31'd0, m0_gnt}, 1);
    check("tie1_m1_gnt", {31'd0, m1_gnt}, 0);
    check("tie1_rd_strb",{31'd0, rd_valid}, 1);
    check("tie1_rd_addr", rd_addr, 32'h100);
    m0_rd_valid = 1'b0;
    s_rdy1 = 1'b1; s_dat1 = 32'hAAAA0001;          // answer in the RD cycle
    step();
    check("tie1_m0_rdy", {31'd0, m0_rd_ready}, 1);
    check("tie1_m0_data", m0_rd_data, 32'hAAAA0001);
    check("tie1_m1_rdy", {31'd0, m1_rd_ready}, 0);
    clear_slaves();
    step();
    check("tie2_m1_gnt", {31'd0, m1_gnt}, 1);
    check("tie2_rd_addr", rd_addr, 32'h200);
    // both request again while m1 read is in flight (must be ignored)
    m0_rd_valid = 1'b1; m0_rd_addr = 32'h104;
    s_rdy0 = 1'b1; s_dat0 = 32'hBBBB0002;
    step();
    check("tie2_m1_rdy", {31'd0, m1_rd_ready}, 1);
    check("tie2_m1_data", m1_rd_data, 32'hBBBB0002);
    check("tie2_m0_nogt",{31'd0, m0_gnt}, 0);
    check("tie2_m0_data", m0_rd_data, 32'hAAAA0001);
    clear_slaves();
    step();
    check("tie3_m0_gnt", {31'd0, m0_gnt}, 1);
    check("tie3_m1_gnt", {31'd0, m1_gnt}, 0);
    check("tie3_rd_addr", rd_addr, 32'h104);
    m0_rd_valid = 1'b0;
    s_rdy3 = 1'b1; s_dat3 = 32'h0000_0003;
    step();
    check("tie3_m0_data", m0_rd_data, 32'h3);
    clear_slaves();
    step();
    check("tie4_m1_gnt", {31'd0, m1_gnt}, 1);
    m1_rd_valid = 1'b0;
    // slaves 1 and 3 together: slave 1 wins
    s_rdy1 = 1'b1; s_dat1 = 32'h11;
    s_rdy3 = 1'b1; s_dat3 = 32'h33;
    step();
    check("prio_m1_rdy", {31'd0, m1_rd_ready}, 1);
    check("prio_m1_data", m1_rd_data, 32'h11);
    clear_slaves();

    // m0 write 0x10 / 0xA5
    m0_wr_valid = 1'b1; m0_wr_addr = 32'h10; m0_wr_data = 32'hA5;
    step();
    check("wr_m0_gnt",   {31'd0, m0_gnt}, 1);
    check("wr_strb",     {31'd0, wr_valid}, 1);
    check("wr_addr",     wr_addr, 32'h10);
    check("wr_data",     wr_data, 32'hA5);
    check("wr_no_rd",    {31'd0, rd_valid}, 0);
    m0_wr_valid = 1'b0;
    s_rdy0 = 1'b1; s_dat0 = 32'h5A5A;             // response during WR is ignored
    step();
    check("wr_strb_off", {31'd0, wr_valid}, 0);
    check("wr_gnt_off",  {31'd0, m0_gnt}, 0);
    check("wr_addr_hold", wr_addr, 32'h10);
    check("wr_ign_rdy",  {31'd0, m0_rd_ready}, 0);
    clear_slaves();

    // m1 read 0x20, slave 2 answers 3 cycles after issue
    m1_rd_valid = 1'b1; m1_rd_addr = 32'h20;
    step();
    check("r35_m1_gnt",  {31'd0, m1_gnt}, 1);
    check("r35_rd_addr", rd_addr, 32'h20);
    m1_rd_valid = 1'b0;
    step();
    check("r35_strb_off",{31'd0, rd_valid}, 0);
    step(2);
    s_rdy2 = 1'b1; s_dat2 = 32'h1234;
    step();
    check("r35_m1_rdy",  {31'd0, m1_rd_ready}, 1);
    check("r35_m1_data", m1_rd_data, 32'h1234);
    check("r35_m0_rdy",  {31'd0, m0_rd_ready}, 0);
    check("r35_m0_data", m0_rd_data, 32'h3);
    clear_slaves();
    // response arriving while IDLE is ignored
    s_rdy0 = 1'b1; s_dat0 = 32'h5555;
    step();
    check("idle_ign_m0", {31'd0, m0_rd_ready}, 0);
    check("idle_ign_m1", {31'd0, m1_rd_ready}, 0);
    check("r35_m1_hold", m1_rd_data, 32'h1234);
    clear_slaves();

    // m0 write and read together: write first, read on a later grant
    m0_wr_valid = 1'b1; m0_wr_addr = 32'h30; m0_wr_data = 32'h77;
    m0_rd_valid = 1'b1; m0_rd_addr = 32'h40;
    step();
    check("wr1st_strb",  {31'd0, wr_valid}, 1);
    check("wr1st_nord",  {31'd0, rd_valid}, 0);
    check("wr1st_addr",  wr_addr, 32'h30);
    m0_wr_valid = 1'b0;
    step();
    check("wr1st_gap",   {31'd0, rd_valid}, 0);
    step();
    check("rd2nd_gnt",   {31'd0, m0_gnt}, 1);
    check("rd2nd_strb",  {31'd0, rd_valid}, 1);
    check("rd2nd_addr",  rd_addr, 32'h40);
    m0_rd_valid = 1'b0;

    // no response: 16 waiting cycles then ERR_DATA
    step(15);
    check("to_not_yet",  {31'd0, m0_rd_ready}, 0);
    check("to_err_low",  {31'd0, err_timeout}, 0);
    step();
    check("to_m0_rdy",   {31'd0, m0_rd_ready}, 1);
    check("to_m0_data",  m0_rd_data, 32'hDEADBEEF);
    check("to_err",      {31'd0, err_timeout}, 1);
    step(3);
    check("to_err_stick",{31'd0, err_timeout}, 1);
    check("to_rdy_off",  {31'd0, m0_rd_ready}, 0);

    // reset in RD_WAIT with a simultaneous slave response
    m1_rd_valid = 1'b1; m1_rd_addr = 32'h50;
    step();
    check("rr_m1_gnt",   {31'd0, m1_gnt}, 1);
    m1_rd_valid = 1'b0;
    step(2);
    c_sys_rst = 1'b1;
    s_rdy0 = 1'b1; s_dat0 = 32'h9999;
    step();
    check("rr_m1_rdy",   {31'd0, m1_rd_ready}, 0);
    check("rr_m1_data",  m1_rd_data, 0);
    check("rr_m0_data",  m0_rd_data, 0);
    check("rr_err",      {31'd0, err_timeout}, 0);
    check("rr_wr_addr",  wr_addr, 0);
    check("rr_rd_addr",  rd_addr, 0);
    c_sys_rst = 1'b0;
    step();
    check("rr_late_rsp", {31'd0, m1_rd_ready}, 0);
    clear_slaves();
    m1_wr_valid = 1'b1; m1_wr_addr = 32'h60; m1_wr_data = 32'h66;
    step();
    check("rr_next_gnt", {31'd0, m1_gnt}, 1);
    check("rr_next_strb",{31'd0, wr_valid}, 1);
    check("rr_next_addr", wr_addr, 32'h60);
    check("rr_next_data", wr_data, 32'h66);
    m1_wr_valid = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
